// File: rtl/line_buffer_feeder.sv
// Raster pixel stream -> three vertically aligned column taps plus 3x3 window strobes.
// Define LINEBUF_CLEAR_EN to zero both line buffers in a CLEAR state before every frame.
module line_buffer_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                          clk,
  input  logic                          Rst_linebuf,
  input  logic                          Start,
  input  logic [DATA_WIDTH-1:0]         in_pixel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_row_n,
  output logic [DATA_WIDTH-1:0]         out_row_n_1,
  output logic [DATA_WIDTH-1:0]         out_row_n_2,
  output logic                          Wr_window,
  output logic                          Shift_window,
  output logic                          Rst_window,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  accept, last_col, last_px;

  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [IMG_WIDTH];
  logic                  lb_we;
  logic [CW-1:0]         lb_addr;
  logic [DATA_WIDTH-1:0] lb1_wdata, lb2_wdata;

  logic                  acc_q;
  logic [DATA_WIDTH-1:0] tap_n_q, tap_n1_q, tap_n2_q;
  logic                  pend_q;
  logic [RW-1:0]         pend_row_q;
  logic [CW-1:0]         pend_col_q;
  logic                  win_valid_q;
  logic [RW-1:0]         win_row_q;
  logic [CW-1:0]         win_col_q;

`ifdef LINEBUF_CLEAR_EN
  logic [CW-1:0]         clr_q, clr_d;
`endif

  assign accept   = in_valid && (state_q == S_STREAM);
  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_px  = last_col && (row_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
`ifdef LINEBUF_CLEAR_EN
    clr_d   = clr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          row_d = '0;
          col_d = '0;
`ifdef LINEBUF_CLEAR_EN
          clr_d   = '0;
          state_d = S_CLEAR;
`else
          state_d = S_STREAM;
`endif
        end
      end
      S_CLEAR: begin
`ifdef LINEBUF_CLEAR_EN
        clr_d = clr_q + CW'(1);
        if (clr_q == CW'(IMG_WIDTH - 1)) state_d = S_STREAM;
`else
        state_d = S_IDLE;
`endif
      end
      S_STREAM: begin
        if (accept) begin
          if (last_px) begin
            state_d = S_DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The old lb1 word is shifted into lb2 in the same cycle it is overwritten.
  always_comb begin
    lb_we     = accept;
    lb_addr   = col_q;
    lb1_wdata = in_pixel;
    lb2_wdata = lb1_mem[col_q];
`ifdef LINEBUF_CLEAR_EN
    if (state_q == S_CLEAR) begin
      lb_we     = 1'b1;
      lb_addr   = clr_q;
      lb1_wdata = '0;
      lb2_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (lb_we && !Rst_linebuf) begin
      lb1_mem[lb_addr] <= lb1_wdata;
      lb2_mem[lb_addr] <= lb2_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst_linebuf) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= 1'b0;
      tap_n_q     <= '0;
      tap_n1_q    <= '0;
      tap_n2_q    <= '0;
      pend_q      <= 1'b0;
      pend_row_q  <= '0;
      pend_col_q  <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
`ifdef LINEBUF_CLEAR_EN
      clr_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= accept;
`ifdef LINEBUF_CLEAR_EN
      clr_q   <= clr_d;
`endif
      // Windows straddling a row wrap are never flagged.
      pend_q  <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (accept) begin
        tap_n_q    <= in_pixel;
        tap_n1_q   <= lb1_mem[col_q];
        tap_n2_q   <= lb2_mem[col_q];
        pend_row_q <= row_q - RW'(1);
        pend_col_q <= col_q - CW'(1);
      end
      win_valid_q <= pend_q;
      if (pend_q) begin
        win_row_q <= pend_row_q;
        win_col_q <= pend_col_q;
      end
    end
  end

  assign in_ready     = (state_q == S_STREAM);
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);
  assign Rst_window   = !Rst_linebuf &&
                        (state_q == S_STREAM || state_q == S_DRAIN || state_q == S_DONE);
  assign Wr_window    = acc_q;
  assign Shift_window = acc_q;
  assign out_row_n    = tap_n_q;
  assign out_row_n_1  = tap_n1_q;
  assign out_row_n_2  = tap_n2_q;
  assign win_valid    = win_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Scoreboard bench for line_buffer_feeder on a 4x4 image: stimulus queues expected
// taps/windows stamped with their due cycle, a negedge monitor pops and compares.
module tb_line_buffer_feeder;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef LINEBUF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          Rst_linebuf, Start, in_valid;
  logic [DW-1:0] in_pixel;
  logic          in_ready;
  logic [DW-1:0] out_row_n, out_row_n_1, out_row_n_2;
  logic          Wr_window, Shift_window, Rst_window, win_valid;
  logic [1:0]    win_row, win_col;
  logic          busy, frame_done;

  always #5 clk = ~clk;

  line_buffer_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .Rst_linebuf(Rst_linebuf), .Start(Start), .in_pixel(in_pixel),
    .in_valid(in_valid), .in_ready(in_ready), .out_row_n(out_row_n),
    .out_row_n_1(out_row_n_1), .out_row_n_2(out_row_n_2), .Wr_window(Wr_window),
    .Shift_window(Shift_window), .Rst_window(Rst_window), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  typedef struct { int cyc; logic [DW-1:0] n; logic [DW-1:0] n1; logic [DW-1:0] n2; bit k1; bit k2; } tap_t;
  typedef struct { int cyc; int r; int c; } win_t;

  tap_t tap_q[$];
  win_t win_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   win_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: one line per presented transaction.
  tap_t t_m;
  win_t w_m;
  always @(negedge clk) begin
    if (Wr_window || Shift_window) begin
      chk("shift_eq_wr", Shift_window, Wr_window);
      if (tap_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_strobe: got strobe, want none (cycle %0d)", cyc);
      end else begin
        t_m = tap_q.pop_front();
        chk("tap_cycle", cyc, t_m.cyc);
        chk("tap_n", out_row_n, t_m.n);
        if (t_m.k1) chk("tap_n_1", out_row_n_1, t_m.n1);
        if (t_m.k2) chk("tap_n_2", out_row_n_2, t_m.n2);
      end
    end
    if (win_valid) begin
      win_seen++;
      if (win_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_win_valid: got win_valid, want none (cycle %0d)", cyc);
      end else begin
        w_m = win_q.pop_front();
        chk("win_cycle", cyc, w_m.cyc);
        chk("win_row", win_row, w_m.r);
        chk("win_col", win_col, w_m.c);
      end
    end
  end

  // Expected column for pixel idx of a frame whose pixels are base+1..base+16.
  task automatic push(input int base, input int idx, input int c0);
    tap_t t;
    win_t w;
    int r, c;
    r = idx / W;
    c = idx % W;
    t.cyc = c0 + 1;
    t.n   = DW'(base + idx + 1);
    t.k1  = (r >= 1) || CLR;
    t.k2  = (r >= 2) || CLR;
    t.n1  = (r >= 1) ? DW'(base + idx + 1 - W) : '0;
    t.n2  = (r >= 2) ? DW'(base + idx + 1 - 2 * W) : '0;
    tap_q.push_back(t);
    if (r >= 2 && c >= 2) begin
      w.cyc = c0 + 2;
      w.r   = r - 1;
      w.c   = c - 1;
      win_q.push_back(w);
    end
  endtask

  task automatic check_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_window", Wr_window, 0);
    chk("rst_shift_window", Shift_window, 0);
    chk("rst_rst_window", Rst_window, 0);
    chk("rst_tap_n", out_row_n, 0);
    chk("rst_tap_n_1", out_row_n_1, 0);
    chk("rst_tap_n_2", out_row_n_2, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  task automatic run_frame(input int base, input bit toggle, input int abort_at);
    int idx, guard;
    bit ph;
    logic v;
    idx = 0; guard = 0; ph = 1'b0;
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
`ifdef LINEBUF_CLEAR_EN
    for (int i = 0; i < W; i++) begin
      chk("clear_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
`endif
    chk("stream_in_ready", in_ready, 1);
    chk("stream_rst_window", Rst_window, 1);
    while (idx < W * H && guard < 200) begin
      if (abort_at > 0 && idx == abort_at) break;
      v  = toggle ? !ph : 1'b1;
      ph = !ph;
      in_valid = v;
      in_pixel = DW'(base + idx + 1);
      Start    = (idx == 5);
      if (v && in_ready) begin
        push(base, idx, cyc);
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    Start    = 1'b0;
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL stream_timeout: got %0d accepted, want %0d", idx, W * H);
    end
    if (abort_at == 0) begin
      chk("drain_in_ready", in_ready, 0);
      chk("drain_busy", busy, 1);
      chk("drain_frame_done", frame_done, 0);
      @(posedge clk); #1;
      chk("done_in_ready", in_ready, 0);
      chk("done_frame_done", frame_done, 1);
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_frame_done", frame_done, 0);
      chk("idle_rst_window", Rst_window, 0);
      chk("frame_win_count", win_seen, 4);
    end
  endtask

  initial begin
    Rst_linebuf = 1'b1;
    Start       = 1'b0;
    in_valid    = 1'b0;
    in_pixel    = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset();
    Rst_linebuf = 1'b0;
    @(posedge clk); #1;

    win_seen = 0;
    run_frame(0, 1'b0, 0);      // continuous pixels 1..16, Start pulsed mid-stream
    win_seen = 0;
    run_frame(0, 1'b1, 0);      // in_valid toggling 1,0,1,0

    win_seen = 0;
    run_frame(200, 1'b0, 6);    // abort after pixel 6
    Rst_linebuf = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset();
    Rst_linebuf = 1'b0;
    @(posedge clk); #1;
    chk("abort_win_count", win_seen, 0);

    win_seen = 0;
    run_frame(100, 1'b0, 0);    // restart must begin at (0,0)

    repeat (5) @(posedge clk);
    #1;
    chk("tap_queue_drained", tap_q.size(), 0);
    chk("win_queue_drained", win_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
